// File: rtl/led_button_sequencer.sv
// Board-test controller: synchronises and debounces an active-low push button,
// classifies short/long presses and steps a 4-mode pattern onto a 3-LED bus.
module led_button_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int TICK_CYCLES       = 8,
    parameter int LONG_PRESS_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_n,
    output logic [2:0] led,
    output logic [1:0] mode,
    output logic       press_pulse,
    output logic       long_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W = $clog2(TICK_CYCLES);
    localparam int HD_W = $clog2(LONG_PRESS_CYCLES + 1);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_STATIC = 2'd1,
        M_BLINK  = 2'd2,
        M_CHASE  = 2'd3
    } mode_t;

    logic            sync1, sync2;
    logic            db_pressed;
    logic [DB_W-1:0] db_cnt;
    logic [HD_W-1:0] hold_cnt;
    logic [TK_W-1:0] tick_cnt;
    mode_t           state;

    logic  sync_pressed, db_flip, press_evt, long_evt, tick_wrap;
    mode_t next_mode;

    assign sync_pressed = ~sync2;
    assign db_flip      = (sync_pressed != db_pressed) &&
                          (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press_evt    = db_flip && !db_pressed;
    // Saturation at LONG_PRESS_CYCLES keeps this from firing twice per press.
    assign long_evt     = db_pressed && (hold_cnt == HD_W'(LONG_PRESS_CYCLES - 1));
    assign tick_wrap    = (tick_cnt == TK_W'(TICK_CYCLES - 1));
    assign next_mode    = mode_t'(state + 2'd1);
    assign mode         = state;

    function automatic logic [2:0] start_pattern(input mode_t m);
        case (m)
            M_STATIC: start_pattern = 3'b111;
            M_BLINK:  start_pattern = 3'b111;
            M_CHASE:  start_pattern = 3'b001;
            default:  start_pattern = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_pressed <= 1'b0;
            db_cnt     <= '0;
        end else if (sync_pressed == db_pressed) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            db_pressed <= ~db_pressed;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (!db_pressed)
            hold_cnt <= '0;
        else if (hold_cnt != HD_W'(LONG_PRESS_CYCLES))
            hold_cnt <= hold_cnt + 1'b1;
    end

    // Mode, LED pattern and tick share one block so a mode change reloads
    // the pattern and restarts the tick on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= M_OFF;
            led         <= 3'b000;
            tick_cnt    <= '0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            press_pulse <= press_evt;
            long_pulse  <= long_evt;
            if (press_evt) begin
                state    <= next_mode;
                led      <= start_pattern(next_mode);
                tick_cnt <= '0;
            end else if (long_evt) begin
                state    <= M_OFF;
                led      <= 3'b000;
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                if (tick_wrap) begin
                    case (state)
                        M_BLINK: led <= ~led;
                        M_CHASE: led <= {led[1:0], led[2]};
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
